// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOTA = 3'b100;
  localparam logic [2:0] OP_RSVD = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  // Function select driven into the 1-bit slice.
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // NOT A reuses the XOR path: b forced to 0 and inverted gives a ^ 1.
  function automatic logic [1:0] op_sel(input logic [2:0] op);
    logic [1:0] sel;
    sel = SEL_AND;
    case (op)
      OP_AND:  sel = SEL_AND;
      OP_OR:   sel = SEL_OR;
      OP_ADD:  sel = SEL_ADD;
      OP_XOR:  sel = SEL_XOR;
      OP_NOTA: sel = SEL_XOR;
      OP_SUB:  sel = SEL_ADD;
      OP_SLT:  sel = SEL_ADD;
      default: sel = SEL_AND;
    endcase
    return sel;
  endfunction

  // Ops that invert B; for SUB/SLT this also seeds the carry to 1.
  function automatic logic op_binv(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOTA);
  endfunction

  // Ops whose final carry is reported on carry_out.
  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice: B inverter, AND, OR, XOR and full adder.
module alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout
);

  logic b_eff;

  assign b_eff = b ^ b_invert;

  // Function select; NOT is obtained as XOR against an inverted zero.
  always_comb begin
    res = 1'b0;
    case (op)
      SEL_AND: res = a & b_eff;
      SEL_OR:  res = a | b_eff;
      SEL_ADD: res = a ^ b_eff ^ cin;
      SEL_XOR: res = a ^ b_eff;
      default: res = 1'b0;
    endcase
  end

  assign cout = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one result bit per clock, LSB first, through one alu_slice.
//
// state  | meaning
// S_IDLE | waiting for start; outputs hold last result
// S_RUN  | processing one bit per cycle, busy=1
// S_DONE | one-cycle done pulse; start here chains the next op
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [2:0]       op_q;
  logic             carry_q;

  logic             accept, last;
  logic             slice_b, slice_res, slice_cout, res_bit;
  logic [WIDTH-1:0] res_full, res_final;
  logic             ovf_msb;

  assign accept = start && (state_q != S_RUN);
  assign last   = (state_q == S_RUN) && (cnt_q == LAST);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);

  // NOT A feeds a zero B so the inverted B turns XOR into NOT.
  assign slice_b = (op_q == OP_NOTA) ? 1'b0 : b_sh[0];

  alu_slice u_slice (
    .a        (a_sh[0]),
    .b        (slice_b),
    .b_invert (op_binv(op_q)),
    .cin      (carry_q),
    .op       (op_sel(op_q)),
    .res      (slice_res),
    .cout     (slice_cout)
  );

  assign res_bit  = (op_q == OP_RSVD) ? 1'b0 : slice_res;
  assign res_full = {res_bit, res_sh};
  assign ovf_msb  = carry_q ^ slice_cout;

  // Final result: SLT collapses to the signed less-than bit.
  always_comb begin
    res_final = res_full;
    if (op_q == OP_SLT) res_final = {{(WIDTH-1){1'b0}}, res_full[WIDTH-1] ^ ovf_msb};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latching, shifting, carry chain and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      op_q    <= OP_AND;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      op_q    <= op;
      carry_q <= op_binv(op);
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_full[WIDTH-1:1];
      carry_q <= slice_cout;
      cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Result and flags update only on the edge entering S_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (last) begin
      result    <= res_final;
      zero      <= (res_final == '0);
      carry_out <= op_arith(op_q) ? slice_cout : 1'b0;
      overflow  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ovf_msb : 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu at WIDTH=8: driver pushes expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = 3'b000;
  logic         busy, done, zero, carry_out, overflow;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         z, c, v;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
        chk({e.name, "_carry"}, 32'(carry_out), 32'(e.c));
        chk({e.name, "_ovf"}, 32'(overflow), 32'(e.v));
        chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input string nm, input logic [W-1:0] r, input logic z, c, v, input int dc);
    exp_t e;
    e.name = nm; e.res = r; e.z = z; e.c = c; e.v = v; e.cyc = dc;
    sb.push_back(e);
  endtask

  // Drive one op at a negedge, register its expectation, drop start after one cycle.
  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] ia, ib,
                       input logic [W-1:0] r, input logic z, c, v);
    @(negedge clk);
    a = ia; b = ib; op = o; start = 1'b1;
    push(nm, r, z, c, v, cyc + W + 1);
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; op = ~o;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int nbusy;
    // Reset state.
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {29'd0, zero, carry_out, overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADD with signed overflow, plus busy-length check.
    a = 8'h7F; b = 8'h01; op = 3'b010; start = 1'b1;
    push("add_ovf", 8'h80, 0, 0, 1, cyc + W + 1);
    nbusy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) break;
    end
    chk("add_ovf_busy_cycles", 32'(nbusy), 8);
    drain();

    // SUB then back-to-back ADD with start held high.
    @(negedge clk);
    a = 8'h05; b = 8'h05; op = 3'b110; start = 1'b1;
    push("sub_eq", 8'h00, 1, 1, 0, cyc + W + 1);
    push("add_b2b", 8'h00, 1, 1, 0, cyc + 2 * (W + 1));
    @(negedge clk);
    a = 8'hFF; b = 8'h01; op = 3'b010;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // SLT.
    issue("slt_neg_lt", 3'b111, 8'h80, 8'h01, 8'h01, 0, 1, 0);
    drain();
    issue("slt_pos_gt", 3'b111, 8'h01, 8'h80, 8'h00, 1, 0, 0);
    drain();
    issue("slt_7f_m1", 3'b111, 8'h7F, 8'hFF, 8'h00, 1, 0, 0);
    drain();

    // Logic ops and reserved code.
    issue("and", 3'b000, 8'hA5, 8'h0F, 8'h05, 0, 0, 0); drain();
    issue("or", 3'b001, 8'hA5, 8'h0F, 8'hAF, 0, 0, 0); drain();
    issue("xor", 3'b011, 8'hA5, 8'h0F, 8'hAA, 0, 0, 0); drain();
    issue("nota", 3'b100, 8'hA5, 8'h0F, 8'h5A, 0, 0, 0); drain();
    issue("rsvd", 3'b101, 8'hA5, 8'h0F, 8'h00, 1, 0, 0); drain();

    // Start during RUN is ignored.
    issue("add_ign", 3'b010, 8'h10, 8'h20, 8'h30, 0, 0, 0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; op = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    chk("ign_result_held", 32'(result), 32'h30);

    // Reset mid-RUN: outputs clear asynchronously, no done.
    @(negedge clk);
    a = 8'h11; b = 8'h22; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_flags", {29'd0, zero, carry_out, overflow}, 0);
    repeat (2) @(negedge clk);
    chk("midrst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);

    issue("add_after_rst", 3'b010, 8'h03, 8'h04, 8'h07, 0, 0, 0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Parametrised multi-cycle ALU that computes a WIDTH-bit result one bit per clock, LSB first, through a single reusable 1-bit slice. It succeeds the combinational 1-bit ALU cell and adds:
- operand latching
- a start/done handshake
- SLT and XOR operations
- zero, carry and overflow status flags

It sits between the lab datapath's register operands and its writeback mux, where area matters more than latency.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥2)
- CNT_W, $clog2(WIDTH), bit-counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- op  in  3  operation code, latched on accepted start
- busy  out  1  high while computing
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  result, held until next accepted start
- zero  out  1  result == 0
- carry_out  out  1  final carry (ADD/SUB/SLT), else 0
- overflow  out  1  signed overflow (ADD/SUB), else 0

## Operation
Op codes:
- 000 AND
- 001 OR
- 010 ADD
- 011 XOR
- 100 NOT A
- 110 SUB
- 111 SLT
- 101 reserved → result 0, flags 0

SUB and SLT set b_invert=1 with carry seeded to 1 (two's complement).

FSM states:
- IDLE: busy=0. start=1 latches a, b and op into shift registers, clears the bit counter, loads carry ← b_invert, and moves to RUN.
- RUN: busy=1. Each cycle the slice processes a_sh[0]/b_sh[0]/carry, and the result bit shifts into result_sh MSB-side. The operands shift right, carry is updated and the counter increments. After the bit at index WIDTH-1, move to DONE. During the MSB cycle, capture overflow = carry_in_msb ^ carry_out_msb.
- DONE: busy=0, done=1 for exactly one cycle. Update result, zero, carry_out and overflow. SLT writes result = {0…0, sum_msb ^ ovf} and zeros overflow, but keeps carry_out. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back allowed).

Rules:
- start while busy=1 is ignored; it is neither queued nor able to corrupt operands.
- a, b and op may change freely after the accepting edge.
- Carry for logic ops is don't-care internally; the carry_out and overflow outputs are forced to 0.
- Reset (any time, including mid-RUN): state=IDLE; busy, done, result, zero, carry_out and overflow = 0; counter and shift registers = 0. No done is produced for an aborted operation.

## Timing
- Accepting edge E0 (start=1, busy=0). busy is high from E0 through edge E0+WIDTH.
- done is high in the cycle after edge E0+WIDTH, i.e. it is observed WIDTH+1 edges after start.
- result and flags change only at the DONE-entry edge. They are stable from then until the edge following the next completed operation.
- Throughput is one operation per WIDTH+1 cycles when start is held high.
- Counter wraps at WIDTH-1 → 0 only on the transition to DONE. It does not rely on power-of-two WIDTH.

## Structure
- Shared package alu_pkg holds:
  - op codes OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOTA, OP_SUB, OP_SLT
  - state encodings S_IDLE, S_RUN, S_DONE
- Sub-module alu_slice is purely combinational, instantiated once.
  - Inputs: a, b, b_invert, cin, op[1:0] select.
  - Outputs: res, cout.
  - Contains the XOR-based B inverter, AND, OR, XOR, NOT and full adder.
- Top level: FSM, counter, shift registers, flag logic.

## Test plan
Benches use WIDTH=8.
- ADD a=0x7F, b=0x01 → result=0x80, overflow=1, carry_out=0, zero=0. done exactly 9 edges after start, busy high for 8 cycles.
- SUB a=0x05, b=0x05 → result=0x00, zero=1, carry_out=1, overflow=0. Then ADD 0xFF+0x01 back-to-back (start held) → 0x00, carry_out=1, second done 9 cycles after first.
- SLT a=0x80 (−128), b=0x01 → result=0x01. SLT a=0x01, b=0x80 → 0x00. a=0x7F, b=0xFF (−1) → 0x00.
- Logic ops on a=0xA5, b=0x0F:
  - AND → 0x05
  - OR → 0xAF
  - XOR → 0xAA
  - NOT A → 0x5A
  - All with carry_out=0, overflow=0.
  - Reserved 101 → 0x00, zero=1.
- start pulsed at cycle 3 of a RUN with different operands → ignored; original result returned, single done.
- rst_n low at cycle 4 of RUN → all outputs 0 asynchronously, no done. A fresh ADD 0x03+0x04 after release → 0x07.
